// File: rtl/float_to_int_pkg.sv
// Shared float format and converter constants.
// Holds the single-precision float payload as produced by the adder datapath,
// the saturation constants for the signed 32-bit result, and the converter
// state encoding used by float_to_int.
package floatingpoint;

  localparam int unsigned FLOAT_EXP_W = 8;
  localparam int unsigned FLOAT_MAN_W = 23;
  localparam int unsigned INT_W       = 32;
  localparam int unsigned MAG_W       = 31;
  localparam int unsigned CNT_W       = 5;

  typedef struct packed {
    logic                   sign;
    logic [FLOAT_EXP_W-1:0] exponent;
    logic [FLOAT_MAN_W-1:0] mantissa;
  } float;

  localparam logic [7:0]  FLOAT_BIAS = 8'd127;
  localparam logic [31:0] INT32_MAX  = 32'h7FFFFFFF;
  localparam logic [31:0] INT32_MIN  = 32'h80000000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ROUND
  } ftoi_state_t;

endpackage

// File: rtl/float_to_int_round.sv
// ftoi_round: round-to-nearest-even increment and conditional negate.
// Ports:
//   mag      aligned integer magnitude (fits in 31 bits, never overflows)
//   guard    first bit below the integer LSB
//   sticky   OR of all bits below guard
//   sign     operand sign
//   result_c signed 32-bit two's-complement result (combinational)
module ftoi_round
  import floatingpoint::*;
(
  input  logic [MAG_W-1:0] mag,
  input  logic             guard,
  input  logic             sticky,
  input  logic             sign,
  output logic [INT_W-1:0] result_c
);

  logic [INT_W-1:0] rounded_c;

  // Round up above half, or at exactly half when the magnitude is odd.
  always_comb begin
    rounded_c = {1'b0, mag} + INT_W'(guard & (sticky | mag[0]));
    result_c  = sign ? (~rounded_c + INT_W'(1)) : rounded_c;
  end

endmodule

// File: rtl/float_to_int.sv
// float_to_int: multi-cycle float -> signed int32 converter, RNE rounding.
// Alignment uses an iterative shifter moving SHIFT_STEP (1, 2 or 4) bits per
// cycle, so latency depends on the operand exponent.
// Ports:
//   Clock, Reset      clock, synchronous active-high reset
//   Op, InputValid    operand and its valid; accepted only when Busy=0
//   Busy              conversion in flight (state != IDLE)
//   Result            signed result, held until the next result
//   ResultValid       one-cycle pulse when Result updates
//   Invalid           NaN/Inf/out-of-range, qualified by ResultValid
//   Inexact           (only with FLOAT_TO_INT_INEXACT_EN) rounding lost bits
module float_to_int
  import floatingpoint::*;
#(
  parameter int unsigned SHIFT_STEP = 1
)
(
  input  logic             Clock,
  input  logic             Reset,
  input  float             Op,
  input  logic             InputValid,
  output logic             Busy,
  output logic [INT_W-1:0] Result,
  output logic             ResultValid,
  output logic             Invalid
`ifdef FLOAT_TO_INT_INEXACT_EN
  ,
  output logic             Inexact
`endif
);

  localparam logic [7:0] EXP_INT_LSB = FLOAT_BIAS + 8'd23;  // e = 23: no shift
  localparam logic [7:0] EXP_TOO_BIG = FLOAT_BIAS + 8'd31;  // e >= 31
  localparam logic [7:0] EXP_HALF    = FLOAT_BIAS - 8'd1;   // e = -1: 0.5..1

  ftoi_state_t      state;
  logic [MAG_W-1:0] mag;
  logic             guard;
  logic             sticky;
  logic             sign;
  logic             left;
  logic [CNT_W-1:0] cnt;
  logic             special;
  logic [INT_W-1:0] spec_res;
  logic             spec_inv;
`ifdef FLOAT_TO_INT_INEXACT_EN
  logic             spec_inx;
`endif

  logic             dec_special_c;
  logic [INT_W-1:0] dec_res_c;
  logic             dec_inv_c;
  logic             dec_inx_c;
  logic             dec_left_c;
  logic [CNT_W-1:0] dec_cnt_c;
  logic [CNT_W-1:0] amt_c;
  logic [MAG_W-1:0] mag_nxt_c;
  logic             guard_nxt_c;
  logic             sticky_nxt_c;
  logic [INT_W-1:0] round_res_c;

  assign Busy = (state != IDLE);

  // Operand classification at capture time.
  always_comb begin
    dec_special_c = 1'b1;
    dec_res_c     = '0;
    dec_inv_c     = 1'b0;
    dec_inx_c     = 1'b0;
    dec_left_c    = (Op.exponent >= EXP_INT_LSB);
    dec_cnt_c     = dec_left_c ? CNT_W'(Op.exponent - EXP_INT_LSB)
                               : CNT_W'(EXP_INT_LSB - Op.exponent);
    if (Op.exponent == 8'hFF) begin
      dec_inv_c = 1'b1;
      dec_res_c = (Op.sign || (Op.mantissa != '0)) ? INT32_MIN : INT32_MAX;
    end else if (Op.exponent >= EXP_TOO_BIG) begin
      // Exactly -2^31 is the one representable value in this range.
      if (Op.sign && (Op.exponent == EXP_TOO_BIG) && (Op.mantissa == '0)) begin
        dec_res_c = INT32_MIN;
      end else begin
        dec_inv_c = 1'b1;
        dec_res_c = Op.sign ? INT32_MIN : INT32_MAX;
      end
    end else if (Op.exponent < EXP_HALF) begin
      dec_inx_c = |{Op.exponent, Op.mantissa};
    end else begin
      dec_special_c = 1'b0;
    end
  end

  // One SHIFT cycle, applied as up to SHIFT_STEP single-bit shifts.
  always_comb begin
    amt_c        = (cnt < CNT_W'(SHIFT_STEP)) ? cnt : CNT_W'(SHIFT_STEP);
    mag_nxt_c    = mag;
    guard_nxt_c  = guard;
    sticky_nxt_c = sticky;
    for (int unsigned i = 0; i < SHIFT_STEP; i++) begin
      if (CNT_W'(i) < amt_c) begin
        if (left) begin
          mag_nxt_c = {mag_nxt_c[MAG_W-2:0], 1'b0};
        end else begin
          sticky_nxt_c = sticky_nxt_c | guard_nxt_c;
          guard_nxt_c  = mag_nxt_c[0];
          mag_nxt_c    = {1'b0, mag_nxt_c[MAG_W-1:1]};
        end
      end
    end
  end

  ftoi_round u_round (
    .mag      (mag),
    .guard    (guard),
    .sticky   (sticky),
    .sign     (sign),
    .result_c (round_res_c)
  );

  // Converter FSM with registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      mag         <= '0;
      guard       <= 1'b0;
      sticky      <= 1'b0;
      sign        <= 1'b0;
      left        <= 1'b0;
      cnt         <= '0;
      special     <= 1'b0;
      spec_res    <= '0;
      spec_inv    <= 1'b0;
      Result      <= '0;
      ResultValid <= 1'b0;
      Invalid     <= 1'b0;
`ifdef FLOAT_TO_INT_INEXACT_EN
      spec_inx    <= 1'b0;
      Inexact     <= 1'b0;
`endif
    end else begin
      ResultValid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (InputValid) begin
            sign     <= Op.sign;
            mag      <= MAG_W'({1'b1, Op.mantissa});
            guard    <= 1'b0;
            sticky   <= 1'b0;
            left     <= dec_left_c;
            cnt      <= dec_cnt_c;
            special  <= dec_special_c;
            spec_res <= dec_res_c;
            spec_inv <= dec_inv_c;
`ifdef FLOAT_TO_INT_INEXACT_EN
            spec_inx <= dec_inx_c;
`endif
            state    <= (dec_special_c || (dec_cnt_c == '0)) ? ROUND : SHIFT;
          end
        end
        SHIFT: begin
          mag    <= mag_nxt_c;
          guard  <= guard_nxt_c;
          sticky <= sticky_nxt_c;
          cnt    <= cnt - amt_c;
          if (cnt == amt_c) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          Result      <= special ? spec_res : round_res_c;
          Invalid     <= special & spec_inv;
          ResultValid <= 1'b1;
`ifdef FLOAT_TO_INT_INEXACT_EN
          Inexact     <= special ? spec_inx : (guard | sticky);
`endif
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef FLOAT_TO_INT_INEXACT_EN
  logic unused_c;
  assign unused_c = dec_inx_c;
`endif

endmodule

// File: doc/float_to_int.md
Name: float_to_int

Overview:
- Multi-cycle converter from the `floatingpoint::float` single-precision format to a signed 32-bit two's-complement integer.
- Rounding is round-to-nearest-even.
- It decodes the float format that the adder datapath produces.
- It sits downstream of the float adder, with the same InputValid/ResultValid handshake style.
- Alignment is an iterative shifter, SHIFT_STEP bits per cycle; latency depends on the data.

Parameters:
SHIFT_STEP, 1, bits shifted per SHIFT cycle; legal values 1, 2, 4.

Ports:
Clock  input  1  clock
Reset  input  1  synchronous, active-high reset
Op  input  float (32)  operand (sign, exponent[7:0], mantissa[22:0])
InputValid  input  1  Op valid; accepted only when Busy=0
Busy  output  1  high while a conversion is in flight
Result  output  32  signed integer result; held until the next result
ResultValid  output  1  one-cycle pulse when Result updates
Invalid  output  1  NaN/Inf/out-of-range flag, qualified by ResultValid

Behaviour:
- Clock is Clock. Reset is Reset, synchronous, active-high.
- On Reset:
  - state IDLE
  - Result=0, ResultValid=0, Invalid=0, Busy=0
  - Reset mid-conversion aborts the conversion with no output pulse.
- States: IDLE, SHIFT, ROUND. Busy = (state != IDLE).
- IDLE:
  - InputValid=1 captures Op on that edge.
  - InputValid while Busy=1 is ignored; it is neither queued nor flagged.
- Decode at capture, with e = exponent - 127 and S = {1, mantissa} (24 bits):
  - exponent=255 (Inf/NaN): special. NaN or -Inf gives 0x80000000; +Inf gives 0x7FFFFFFF; Invalid=1.
  - e >= 31: special. Op = 0xCF000000 (exactly -2^31) gives 0x80000000 with Invalid=0. All other values saturate (sign ? 0x80000000 : 0x7FFFFFFF) with Invalid=1.
  - exponent < 126 (includes zero and denormals; magnitude < 0.5): special, result 0, Invalid=0. -0.0 also gives 0.
  - Otherwise normal (-1 <= e <= 30): direction = left if e >= 23, else right. Shift count N = |e - 23|, 0..24.
- Transitions:
  - Special, or normal with N=0: IDLE -> ROUND.
  - Normal with N>0: IDLE -> SHIFT.
- SHIFT: each cycle shifts the magnitude register by min(SHIFT_STEP, remaining) and decrements the count by the same amount.
  - Right shift:
    - The guard bit takes the last bit shifted out.
    - All earlier shifted-out bits, and the previous guard, are ORed into sticky.
  - Left shift: zero fill; guard=sticky=0.
  - On the edge where the count reaches 0: -> ROUND.
- ROUND, one cycle:
  - mag = mag + (guard & (sticky | mag[0])).
  - Result = sign ? -mag : mag.
  - ResultValid=1 for this one cycle; -> IDLE.
  - mag never exceeds 2^31 - 128, so no overflow after rounding.
- Latency:
  - ResultValid is high ceil(N/SHIFT_STEP)+1 cycles after the accept edge.
  - Special cases: 1 cycle.
- Back-to-back: the cycle where ResultValid=1 has state IDLE, so a new Op may be accepted in that same cycle.
- Invalid:
  - Registered alongside Result.
  - Meaningful only when ResultValid=1; held afterwards.

Optional Feature:
- Macro FLOAT_TO_INT_INEXACT_EN.
- Defined:
  - Adds output port Inexact (1 bit), registered in ROUND: Inexact = guard | sticky for normal conversions.
  - Inexact=1 for nonzero values flushed to 0 (exponent < 126, nonzero, not NaN/Inf).
  - Inexact=0 when Invalid=1 and for the exact -2^31 case.
  - Reset value 0.
- Undefined: the port is absent and the logic is removed.

Decomposition:
- Package floatingpoint: existing float typedef, plus FLOAT_BIAS=8'd127, INT32_MAX=32'h7FFFFFFF, INT32_MIN=32'h80000000, and enum ftoi_state_t {IDLE, SHIFT, ROUND}.
- One sub-module, ftoi_round: combinational RNE increment plus conditional two's-complement negate.
  - Inputs: mag[30:0], guard, sticky, sign.
  - Output: the 32-bit result.

Test Plan:
- 0x3F800000 (1.0), SHIFT_STEP=1 -> Result=1, Invalid=0, ResultValid pulses 24 cycles after accept; Busy high for those 24 cycles.
- 0x40200000 (2.5) -> 2; 0x40600000 (3.5) -> 4; 0xBFC00000 (-1.5) -> 0xFFFFFFFE. Covers tie-to-even both ways and negation.
- 0x4E6E6B28 (1e9) -> 0x3B9ACA00, latency 7. 0x4F32D05E (3e9) -> 0x7FFFFFFF, Invalid=1. 0xCF000000 -> 0x80000000, Invalid=0. 0x7FC00000 (NaN) -> 0x80000000, Invalid=1, latency 1.
- 0x3F000000 (0.5) -> 0; 0x3F000001 -> 1; 0x00000001 (denormal) -> 0, Invalid=0, latency 1.
- Handshake and reset:
  - InputValid held high continuously: only one Op accepted per conversion, a new accept occurs on the ResultValid cycle, no result is lost.
  - Reset asserted during SHIFT: next cycle Busy=0, ResultValid=0, Result=0, and no pulse follows.
- SHIFT_STEP=4 with 1.0 -> Result=1, ResultValid 7 cycles after accept. Macro defined: 2.5 -> Inexact=1; 1.0 -> Inexact=0.
